// File: rtl/irrigation_scheduler_pkg.sv
// Shared types and helpers for the multi-zone irrigation scheduler.
package irrigation_scheduler_pkg;
`include "irrigation_defs.vh"

    typedef enum logic [1:0] {
        ST_IDLE = `IRR_IDLE,
        ST_RUN  = `IRR_RUN,
        ST_REST = `IRR_REST
    } irr_state_e;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/irrigation_debounce.sv
// Per-zone dryness debouncer: eligible after DEBOUNCE consecutive dry samples.
module irrigation_debounce #(
    parameter int DEBOUNCE = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic wet,
    output logic eligible
);
    localparam int CW = $clog2(DEBOUNCE + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (wet) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(DEBOUNCE)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign eligible = (cnt_q == CW'(DEBOUNCE));
endmodule

// File: rtl/irrigation_defs.vh
// State encodings shared by the irrigation family of blocks.
`ifndef IRRIGATION_DEFS_VH
`define IRRIGATION_DEFS_VH
`define IRR_IDLE 2'd0
`define IRR_RUN  2'd1
`define IRR_REST 2'd2
`endif

// File: rtl/irrigation_scheduler.sv
// Round-robin multi-zone irrigation scheduler: debounced eligibility, timed
// watering per grant, then a mandatory rest period before the next grant.
module irrigation_scheduler
    import irrigation_scheduler_pkg::*;
#(
    parameter int ZONES       = 4,
    parameter int DEBOUNCE    = 8,
    parameter int RUN_CYCLES  = 100,
    parameter int REST_CYCLES = 20,
    localparam int ZW = (ZONES > 1) ? $clog2(ZONES) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             error,
    input  logic             water_ok,
    input  logic [ZONES-1:0] earth_humidity,
    input  logic [ZONES-1:0] sprinkler_sel,
    output logic [ZONES-1:0] valve,
    output logic             dripper,
    output logic             sprinkler,
    output logic [ZW-1:0]    zone_idx,
    output logic             busy,
    output logic             fault
);
    localparam int TW = imax(1, $clog2(imax(RUN_CYCLES, REST_CYCLES)));

    irr_state_e       state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [ZW-1:0]    zone_idx_q, zone_idx_d;
    logic [ZW-1:0]    last_grant_q, last_grant_d;
    logic             fault_q, fault_d;
    logic [ZONES-1:0] eligible;
    logic             permit;
    logic [ZW-1:0]    grant;
    logic             run;

    for (genvar g = 0; g < ZONES; g++) begin : g_db
        irrigation_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
            .clk      (clk),
            .rst_n    (rst_n),
            .wet      (earth_humidity[g]),
            .eligible (eligible[g])
        );
    end

    // First eligible zone strictly after the last grant, wrapping modulo ZONES.
    function automatic logic [ZW-1:0] rr_pick(input logic [ZONES-1:0] elig,
                                              input logic [ZW-1:0]    last);
        logic [ZW-1:0] pick;
        logic          found;
        int            idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= ZONES; k++) begin
            idx = (int'(last) + k) % ZONES;
            if (!found && elig[idx]) begin
                pick  = ZW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign permit = enable & ~error & water_ok;
    assign grant  = rr_pick(eligible, last_grant_q);

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        zone_idx_d   = zone_idx_q;
        last_grant_d = last_grant_q;
        fault_d      = error | ~water_ok;
        case (state_q)
            ST_IDLE: begin
                if (permit && (|eligible)) begin
                    state_d      = ST_RUN;
                    zone_idx_d   = grant;
                    last_grant_d = grant;
                    timer_d      = TW'(RUN_CYCLES - 1);
                end
            end
            ST_RUN: begin
                // Expiry, abort and early satisfaction all collapse into one exit.
                if ((timer_q == '0) || !permit || earth_humidity[zone_idx_q]) begin
                    state_d = ST_REST;
                    timer_d = TW'(REST_CYCLES - 1);
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_REST: begin
                if (timer_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            zone_idx_q   <= '0;
            last_grant_q <= ZW'(ZONES - 1);
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            zone_idx_q   <= zone_idx_d;
            last_grant_q <= last_grant_d;
            fault_q      <= fault_d;
        end
    end

    assign run = (state_q == ST_RUN);

    always_comb begin
        valve = '0;
        for (int i = 0; i < ZONES; i++) begin
            valve[i] = run && (zone_idx_q == ZW'(i));
        end
    end

    assign sprinkler = run &  sprinkler_sel[zone_idx_q];
    assign dripper   = run & ~sprinkler_sel[zone_idx_q];
    assign zone_idx  = zone_idx_q;
    assign busy      = (state_q != ST_IDLE);
    assign fault     = fault_q;
endmodule

// File: tb/tb_irrigation_scheduler.sv
// Scoreboard bench: a cycle-level behavioural model queues expected outputs,
// a negedge monitor pops and compares them against the scheduler.
module tb_irrigation_scheduler;
    localparam int Z   = 4;
    localparam int DB  = 4;
    localparam int RUN = 8;
    localparam int RST = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b1;
    logic         error = 1'b0;
    logic         water_ok = 1'b1;
    logic [Z-1:0] earth_humidity = '1;
    logic [Z-1:0] sprinkler_sel = '0;
    logic [Z-1:0] valve;
    logic         dripper;
    logic         sprinkler;
    logic [1:0]   zone_idx;
    logic         busy;
    logic         fault;

    irrigation_scheduler #(
        .ZONES(Z), .DEBOUNCE(DB), .RUN_CYCLES(RUN), .REST_CYCLES(RST)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .error          (error),
        .water_ok       (water_ok),
        .earth_humidity (earth_humidity),
        .sprinkler_sel  (sprinkler_sel),
        .valve          (valve),
        .dripper        (dripper),
        .sprinkler      (sprinkler),
        .zone_idx       (zone_idx),
        .busy           (busy),
        .fault          (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    cyc;
        int    valve;
        bit    busy;
        bit    fault;
        int    zone;
        bit    watering;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cycle_no = 0;

    // Behavioural model: mode 0 = idle, 1 = watering, 2 = resting.
    int dry_cnt[Z];
    int m_mode = 0;
    int m_left = 0;
    int m_zone = 0;
    int m_last = Z - 1;
    bit m_fault = 0;

    task automatic model_step();
        bit permit;
        bit any_elig;
        exp_t e;
        if (!rst_n) begin
            foreach (dry_cnt[i]) dry_cnt[i] = 0;
            m_mode = 0; m_left = 0; m_zone = 0; m_last = Z - 1; m_fault = 0;
        end else begin
            permit = enable && !error && water_ok;
            any_elig = 0;
            foreach (dry_cnt[i]) if (dry_cnt[i] >= DB) any_elig = 1;
            if (m_mode == 0) begin
                if (permit && any_elig) begin
                    for (int k = 1; k <= Z; k++) begin
                        if (dry_cnt[(m_last + k) % Z] >= DB) begin
                            m_zone = (m_last + k) % Z;
                            break;
                        end
                    end
                    m_last = m_zone;
                    m_mode = 1;
                    m_left = RUN;
                end
            end else if (m_mode == 1) begin
                m_left--;
                if (m_left == 0 || !permit || earth_humidity[m_zone]) begin
                    m_mode = 2;
                    m_left = RST;
                end
            end else begin
                m_left--;
                if (m_left == 0) m_mode = 0;
            end
            foreach (dry_cnt[i])
                dry_cnt[i] = earth_humidity[i] ? 0 : ((dry_cnt[i] < DB) ? dry_cnt[i] + 1 : DB);
            m_fault = error || !water_ok;
        end
        e.cyc      = cycle_no;
        e.watering = (m_mode == 1);
        e.valve    = e.watering ? (1 << m_zone) : 0;
        e.busy     = (m_mode != 0);
        e.fault    = m_fault;
        e.zone     = m_zone;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cycle_no++;
        #1;
    endtask

    task automatic check(input string name, input int cyc, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("valve",     e.cyc, int'(valve),     e.valve);
            check("busy",      e.cyc, int'(busy),      int'(e.busy));
            check("fault",     e.cyc, int'(fault),     int'(e.fault));
            check("zone_idx",  e.cyc, int'(zone_idx),  e.zone);
            check("sprinkler", e.cyc, int'(sprinkler), e.watering ? int'(sprinkler_sel[e.zone]) : 0);
            check("dripper",   e.cyc, int'(dripper),   e.watering ? int'(!sprinkler_sel[e.zone]) : 0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cycle_no);
        $fatal(1);
    end

    initial begin
        // Reset
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;

        // Single zone 2 dry, dripper mode
        earth_humidity = 4'b1011; sprinkler_sel = 4'b0000;
        repeat (25) tick();
        earth_humidity = 4'b1111;
        repeat (4) tick();

        // Round robin, all dry, sprinkler on odd zones
        earth_humidity = 4'b0000; sprinkler_sel = 4'b1010;
        repeat (70) tick();

        // Abort by error at a random point inside a grant
        repeat ($urandom_range(0, 10)) tick();
        error = 1'b1;
        repeat (4) tick();
        error = 1'b0;
        repeat (30) tick();

        // Early satisfied: wait for watering, then wet the granted zone
        for (int n = 0; n < 20 && !(busy && valve != 0); n++) tick();
        tick();
        earth_humidity[zone_idx] = 1'b1;
        repeat (8) tick();
        earth_humidity = 4'b0000;

        // No water: nothing may open
        water_ok = 1'b0;
        repeat (40) tick();
        water_ok = 1'b1;

        // Dry glitch on zone 1 shorter than the debounce window
        earth_humidity = 4'b1111;
        repeat (10) tick();
        earth_humidity = 4'b1101;
        repeat (3) tick();
        earth_humidity = 4'b1111;
        repeat (10) tick();

        // Reset mid-grant, then restart from zone 0
        earth_humidity = 4'b0000;
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (20) tick();

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < Z; i++)
                if ($urandom_range(0, 11) == 0) earth_humidity[i] = ~earth_humidity[i];
            error    = ($urandom_range(0, 49) == 0);
            water_ok = ($urandom_range(0, 39) != 0);
            enable   = ($urandom_range(0, 39) != 0);
            rst_n    = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 19) == 0) sprinkler_sel = Z'($urandom);
            tick();
        end
        rst_n = 1'b1; enable = 1'b1; error = 1'b0; water_ok = 1'b1;
        repeat (3) tick();

        @(negedge clk);
        @(negedge clk);
        check("drain", cycle_no, exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
